// File: rtl/bch_encode.sv
// Serial systematic BCH encoder: message bits pass straight through, then the
// remainder of the generator-polynomial division LFSR is shifted out MSB-first.
module bch_encode #(
    parameter int N = 15,
    parameter int K = 7,
    parameter int T = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic data_in,
    input  logic data_valid,
    output logic data_ready,
    output logic data_out,
    output logic output_valid,
    output logic output_first,
    output logic output_last
);
    localparam int MAXN = 255;

    function automatic int n2m(input int n);
        int m;
        m = 1;
        while (((1 << m) - 1) < n) m++;
        return m;
    endfunction

    localparam int M  = n2m(N);
    localparam int P  = N - K;
    localparam int PW = $clog2(N);

    function automatic int prim_poly(input int m);
        case (m)
            2:       return 'h7;
            3:       return 'hB;
            4:       return 'h13;
            5:       return 'h25;
            6:       return 'h43;
            7:       return 'h89;
            8:       return 'h11D;
            default: return 0;
        endcase
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        logic [8:0] xs;
        int         pp;
        pp  = prim_poly(M);
        acc = '0;
        x   = a;
        for (int i = 0; i < M; i++) begin
            if (b[i]) acc = acc ^ x;
            xs = {1'b0, x} << 1;
            if (x[M-1]) xs = xs ^ pp[8:0];
            x = xs[7:0];
        end
        return acc;
    endfunction

    // Union of the cyclotomic cosets of alpha^1, alpha^3, ..., alpha^(2T-1).
    function automatic logic [MAXN-1:0] root_set();
        logic [MAXN-1:0] s;
        int              e;
        s = '0;
        for (int i = 1; i < 2 * T; i += 2) begin
            e = i % N;
            for (int j = 0; j < M; j++) begin
                s[e] = 1'b1;
                e = (2 * e) % N;
            end
        end
        return s;
    endfunction

    function automatic int root_count();
        logic [MAXN-1:0] s;
        int              cnt;
        s   = root_set();
        cnt = 0;
        for (int i = 0; i < MAXN; i++) cnt += int'(s[i]);
        return cnt;
    endfunction

    // Multiply out (x + alpha^r) over every root; the result has GF(2) coefficients.
    function automatic logic [MAXN:0] gen_poly();
        logic [8*(MAXN+1)-1:0] c;
        logic [MAXN-1:0]       roots;
        logic [MAXN:0]         g;
        logic [7:0]            a;
        logic [7:0]            lower;
        int                    deg;
        int                    lo;
        roots    = root_set();
        c        = '0;
        c[7:0]   = 8'd1;
        deg      = 0;
        a        = 8'd1;
        for (int r = 0; r < N; r++) begin
            if (roots[r]) begin
                for (int j = deg + 1; j >= 0; j--) begin
                    lo    = (j > 0) ? j - 1 : 0;
                    lower = (j > 0) ? c[8*lo +: 8] : 8'd0;
                    c[8*j +: 8] = lower ^ gf_mul(a, c[8*j +: 8]);
                end
                deg++;
            end
            a = gf_mul(a, 8'd2);
        end
        g = '0;
        for (int j = 0; j <= MAXN; j++) g[j] = c[8*j];
        return g;
    endfunction

    localparam logic [MAXN:0] G_FULL = gen_poly();
    localparam int            G_DEG  = root_count();
    localparam logic [P-1:0]  G_LOW  = G_FULL[P-1:0];

    generate
        if (G_DEG != P || N != (1 << M) - 1 || M > 8) begin : g_param_check
            $error("bch_encode: generator degree %0d incompatible with N=%0d K=%0d", G_DEG, N, K);
        end
    endgenerate

    localparam logic [PW-1:0] K_POS    = PW'(K);
    localparam logic [PW-1:0] LAST_POS = PW'(N - 1);

    logic [PW-1:0] pos;
    logic [P-1:0]  lfsr;
    logic          msg_phase;
    logic          accept;
    logic          fb;

    assign msg_phase  = (pos < K_POS);
    assign data_ready = msg_phase && !reset;
    assign accept     = data_ready && data_valid;
    assign fb         = data_in ^ lfsr[P-1];

    // After the last parity shift the LFSR is empty, so wrapping pos starts a clean frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            pos          <= '0;
            lfsr         <= '0;
            data_out     <= 1'b0;
            output_valid <= 1'b0;
            output_first <= 1'b0;
            output_last  <= 1'b0;
        end else if (msg_phase) begin
            output_last <= 1'b0;
            if (accept) begin
                lfsr         <= {lfsr[P-2:0], 1'b0} ^ (fb ? G_LOW : '0);
                data_out     <= data_in;
                output_valid <= 1'b1;
                output_first <= (pos == '0);
                pos          <= pos + 1'b1;
            end else begin
                data_out     <= 1'b0;
                output_valid <= 1'b0;
                output_first <= 1'b0;
            end
        end else begin
            data_out     <= lfsr[P-1];
            lfsr         <= {lfsr[P-2:0], 1'b0};
            output_valid <= 1'b1;
            output_first <= 1'b0;
            output_last  <= (pos == LAST_POS);
            pos          <= (pos == LAST_POS) ? '0 : pos + 1'b1;
        end
    end
endmodule

// File: tb/tb_bch_encode.sv
// Self-checking bench for bch_encode: directed codewords plus random frames
// compared with a polynomial-division model and a nearest-codeword decoder.
module tb_bch_encode;
    localparam int N = 15;
    localparam int K = 7;
    localparam int P = 8;
    localparam logic [P:0] G_REF = 9'h1D1;

    logic clk = 1'b0;
    logic reset;
    logic data_in;
    logic data_valid;
    logic data_ready;
    logic data_out;
    logic output_valid;
    logic output_first;
    logic output_last;

    int checks = 0;
    int passes = 0;
    logic [N-1:0] cw_table [0:(1<<K)-1];

    bch_encode #(.N(N), .K(K), .T(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .data_out     (data_out),
        .output_valid (output_valid),
        .output_first (output_first),
        .output_last  (output_last)
    );

    always #5 clk = ~clk;

    // Systematic codeword: message in the top K bits, remainder of m(x)*x^P mod g(x) below.
    function automatic logic [N-1:0] ref_codeword(input logic [K-1:0] msg);
        logic [N-1:0] r;
        logic [N-1:0] g;
        r = {msg, {P{1'b0}}};
        g = {{(N-P-1){1'b0}}, G_REF};
        for (int d = N - 1; d >= P; d--)
            if (r[d]) r = r ^ (g << (d - P));
        return {msg, r[P-1:0]};
    endfunction

    function automatic logic [K-1:0] nearest_message(input logic [N-1:0] rx);
        int best;
        int bestd;
        int d;
        best  = 0;
        bestd = N + 1;
        for (int m = 0; m < (1 << K); m++) begin
            d = $countones(rx ^ cw_table[m]);
            if (d < bestd) begin
                bestd = d;
                best  = m;
            end
        end
        return K'(best);
    endfunction

    // Sends one message, optionally pausing data_valid, and collects N output bits.
    task automatic run_frame(input logic [K-1:0] msg, input int stall_at, input int stall_len,
                             output logic [N-1:0] cw, output int gaps, output int parity_gaps,
                             output int flag_err, output int timeout);
        int   sent;
        int   got;
        int   cyc;
        int   stalled;
        logic in_stall;
        logic acc;
        sent = 0; got = 0; cyc = 0; stalled = 0;
        gaps = 0; parity_gaps = 0; flag_err = 0; timeout = 0;
        cw = '0;
        while (got < N && cyc < 100) begin
            in_stall = (sent < K) && (sent == stall_at) && (stalled < stall_len);
            if (sent < K && !in_stall) begin
                data_valid = 1'b1;
                data_in    = msg[K-1-sent];
            end else begin
                data_valid = 1'b0;
                data_in    = 1'($urandom);
            end
            acc = data_valid && data_ready;
            @(posedge clk);
            #1;
            cyc++;
            if (acc) sent++;
            if (in_stall) stalled++;
            if (output_valid) begin
                cw[N-1-got] = data_out;
                if (output_first !== (got == 0)) flag_err++;
                if (output_last !== (got == N - 1)) flag_err++;
                got++;
            end else if (got > 0) begin
                gaps++;
                if (got >= K) parity_gaps++;
            end
        end
        data_valid = 1'b0;
        if (got < N) timeout = 1;
    endtask

    task automatic test_reset();
        reset = 1'b1; data_valid = 1'b1; data_in = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (data_ready !== 1'b0)
            $display("[TB] FAIL reset_ready: got %b expected 0", data_ready);
        else passes++;
        checks++;
        if ({data_out, output_valid, output_first, output_last} !== 4'b0000)
            $display("[TB] FAIL reset_outputs: got %b expected 0000",
                     {data_out, output_valid, output_first, output_last});
        else passes++;
        reset = 1'b0; data_valid = 1'b0;
        #1;
        checks++;
        if (data_ready !== 1'b1)
            $display("[TB] FAIL ready_after_reset: got %b expected 1", data_ready);
        else passes++;
    endtask

    task automatic test_all_zero();
        logic [4:0] obs;
        logic [4:0] expv;
        logic       rdy;
        for (int c = 0; c < N; c++) begin
            data_valid = 1'b1;
            data_in    = 1'b0;
            #1;
            rdy = data_ready;
            @(posedge clk);
            #1;
            obs  = {rdy, output_valid, output_first, output_last, data_out};
            expv = {(c < K), 1'b1, (c == 0), (c == N - 1), 1'b0};
            checks++;
            if (obs !== expv)
                $display("[TB] FAIL all_zero_cycle%0d: got %b expected %b", c, obs, expv);
            else passes++;
        end
        data_valid = 1'b0;
    endtask

    task automatic directed(input string name, input logic [K-1:0] msg, input int stall_at,
                            input int stall_len, input logic [N-1:0] expect_cw,
                            input int expect_gaps);
        logic [N-1:0] cw;
        int gaps, pgaps, ferr, tmo;
        run_frame(msg, stall_at, stall_len, cw, gaps, pgaps, ferr, tmo);
        checks++;
        if (cw !== expect_cw || tmo != 0)
            $display("[TB] FAIL %s_codeword: got %b expected %b (timeout %0d)", name, cw, expect_cw, tmo);
        else passes++;
        checks++;
        if (ferr != 0 || gaps != expect_gaps || pgaps != 0)
            $display("[TB] FAIL %s_framing: got flag_err=%0d gaps=%0d parity_gaps=%0d expected 0/%0d/0",
                     name, ferr, gaps, pgaps, expect_gaps);
        else passes++;
    endtask

    task automatic test_vectors();
        directed("all_ones", 7'h7F, -1, 0, 15'h7FFF, 0);
        directed("unit", 7'h01, -1, 0, 15'b000000111010001, 0);
    endtask

    task automatic test_stall();
        directed("stall", 7'h01, 3, 3, 15'b000000111010001, 3);
    endtask

    task automatic test_reset_in_par();
        int stray;
        for (int c = 0; c < K + 3; c++) begin
            data_valid = 1'b1;
            data_in    = 1'b1;
            @(posedge clk);
            #1;
        end
        data_valid = 1'b0;
        reset = 1'b1;
        #1;
        checks++;
        if (data_ready !== 1'b0)
            $display("[TB] FAIL par_reset_ready: got %b expected 0", data_ready);
        else passes++;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if ({output_valid, output_last, data_out} !== 3'b000)
            $display("[TB] FAIL par_reset_outputs: got %b expected 000",
                     {output_valid, output_last, data_out});
        else passes++;
        stray = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (output_valid) stray++;
        end
        checks++;
        if (stray != 0)
            $display("[TB] FAIL par_reset_stray: got %0d valid cycles expected 0", stray);
        else passes++;
        directed("after_reset", 7'h01, -1, 0, 15'b000000111010001, 0);
    endtask

    task automatic test_back_to_back();
        logic [K-1:0] msg [0:2];
        logic [N-1:0] expcw;
        logic [4:0]   obs;
        logic [4:0]   expv;
        logic         rdy;
        int           ph;
        int           f;
        for (int i = 0; i < 3; i++) msg[i] = K'($urandom);
        for (int c = 0; c < 3 * N; c++) begin
            f  = c / N;
            ph = c % N;
            data_valid = 1'b1;
            data_in    = (ph < K) ? msg[f][K-1-ph] : 1'($urandom);
            #1;
            rdy = data_ready;
            @(posedge clk);
            #1;
            expcw = ref_codeword(msg[f]);
            obs   = {rdy, output_valid, output_first, output_last, data_out};
            expv  = {(ph < K), 1'b1, (ph == 0), (ph == N - 1), expcw[N-1-ph]};
            checks++;
            if (obs !== expv)
                $display("[TB] FAIL b2b_cycle%0d: got %b expected %b", c, obs, expv);
            else passes++;
        end
        data_valid = 1'b0;
    endtask

    task automatic test_random();
        logic [K-1:0] msg;
        logic [N-1:0] cw;
        logic [N-1:0] expcw;
        logic [N-1:0] err;
        logic [K-1:0] dec;
        int gaps, pgaps, ferr, tmo, sa, sl, nerr, expgaps;
        for (int fr = 0; fr < 1000; fr++) begin
            msg = K'($urandom);
            sa  = $urandom_range(0, K - 1);
            sl  = $urandom_range(0, 2);
            run_frame(msg, sa, sl, cw, gaps, pgaps, ferr, tmo);
            expcw   = ref_codeword(msg);
            expgaps = (sa == 0) ? 0 : sl;
            checks++;
            if (cw !== expcw || tmo != 0 || ferr != 0 || gaps != expgaps || pgaps != 0)
                $display("[TB] FAIL random_frame%0d: got %b (flags %0d gaps %0d/%0d tmo %0d) expected %b",
                         fr, cw, ferr, gaps, pgaps, tmo, expcw);
            else passes++;
            nerr = $urandom_range(0, 2);
            err  = '0;
            while ($countones(err) < nerr) err[$urandom_range(0, N - 1)] = 1'b1;
            dec = nearest_message(cw ^ err);
            checks++;
            if (dec !== msg)
                $display("[TB] FAIL random_decode%0d: got %b expected %b (errors %0d)", fr, dec, msg, nerr);
            else passes++;
        end
    endtask

    initial begin
        for (int m = 0; m < (1 << K); m++) cw_table[m] = ref_codeword(K'(m));
        reset = 1'b1; data_valid = 1'b0; data_in = 1'b0;
        test_reset();
        test_all_zero();
        test_vectors();
        test_stall();
        test_reset_in_par();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/bch_encode.md
# bch_encode

Serial systematic BCH encoder, the transmit-side counterpart of the double-error decoder. It accepts K message bits one per cycle through a valid/ready handshake, forwards them unchanged, then appends N-K parity bits computed by a generator-polynomial division LFSR. The result is an N-bit codeword stream, highest-degree coefficient first, in the bit order the decoder consumes. It sits between the payload source and the channel/serializer.

## Interface

- N, 15, codeword length; N = 2^M - 1, M = n2m(N).
- K, 7, message length.
- T, 2, correctable errors; selects the generator polynomial.

Ports:

- clk, input, 1, sole clock; all state updates on its rising edge.
- reset, input, 1, synchronous, active-high; clears all state.
- data_in, input, 1, message bit; sampled only on accept.
- data_valid, input, 1, upstream has a bit on data_in.
- data_ready, output, 1, encoder is in the message phase and not in reset.
- data_out, output, 1, codeword bit, registered.
- output_valid, output, 1, data_out carries a codeword bit.
- output_first, output, 1, data_out is codeword bit N-1 (the first bit).
- output_last, output, 1, data_out is codeword bit 0 (the last parity bit).

## Operation

- Generator g(x): the product of the distinct minimal polynomials of alpha^1, alpha^3, …, alpha^(2T-1) over GF(2^M), computed at elaboration.
  - Degree P = N-K is required; any mismatch is an elaboration error.
  - With the defaults, g = x^8+x^7+x^6+x^4+1 (0x1D1), using primitive polynomial x^4+x+1.
- State:
  - Position counter pos, 0..N-1, width clog2(N).
  - P-bit parity register lfsr.
- Two phases, decoded from pos:
  - MSG: pos < K.
  - PAR: pos >= K.
- Accept means data_ready && data_valid.
- MSG phase:
  - data_ready = !reset.
  - On accept:
    - fb = data_in ^ lfsr[P-1].
    - lfsr <= (lfsr << 1) ^ (fb ? g[P-1:0] : 0).
    - data_out <= data_in; output_valid <= 1.
    - output_first <= (pos == 0).
    - pos <= pos + 1.
  - Without accept:
    - pos and lfsr hold.
    - output_valid <= 0, output_first <= 0, output_last <= 0.
    - data_out <= 0.
  - Stall length is unbounded.
- PAR phase:
  - data_ready = 0; no stall possible.
  - Every cycle:
    - data_out <= lfsr[P-1]; lfsr <= lfsr << 1.
    - output_valid <= 1.
    - output_last <= (pos == N-1).
  - At pos == N-1, pos wraps to 0. lfsr is then all-zero, so no explicit clear is needed.
- Parity is emitted MSB-first (coefficient x^(P-1) down to x^0).
- reset:
  - pos <= 0, lfsr <= 0.
  - data_out, output_valid, output_first, output_last <= 0.
  - data_ready is low during every reset cycle.
  - A partial frame is discarded with no further output. The next frame starts at message bit 0.
- data_valid is ignored when data_ready is low. data_in is ignored when there is no accept.

## Timing

- Latency: bit accepted at cycle t appears on data_out with output_valid at t+1.
- PAR phase:
  - Entered the cycle after the K-th accept.
  - Lasts exactly P cycles.
  - Its output appears at t+1 relative to each PAR cycle.
- data_ready:
  - Combinational from pos and reset.
  - Deasserts in the cycle after the K-th accept.
  - Reasserts in the cycle after the last PAR cycle.
- Back-to-back frames: with data_valid held high, a frame takes exactly N cycles. output_valid stays continuously high, and output_first follows output_last in the next cycle.
- Minimum frame period is N cycles; maximum throughput is K/N.
- Reset values: data_ready 0 while reset is high. data_out, output_valid, output_first and output_last are 0 in the cycle after reset is sampled.
- First accept is possible in the first cycle with reset low.
- If reset is asserted during PAR, remaining parity bits are suppressed from the next cycle.

## Test plan

- All-zero message, data_valid constantly high → 15 consecutive output_valid cycles.
  - data_out all 0.
  - output_first in cycle 1, output_last in cycle 15.
  - data_ready high for cycles 0–6, low for cycles 7–14.
- Message 1111111 → codeword 111111111111111 (all-ones is a codeword of the default code).
- Message 0000001 → codeword 000000111010001, which equals g(x).
- Message 0000001 with data_valid low for 3 cycles after bit 2 → same codeword.
  - output_valid low for exactly those 3 cycles.
  - Parity burst of 8 uninterrupted bits.
- Reset asserted for one cycle at PAR position 3 of a 1111111 frame.
  - No further output_valid.
  - The next frame, 0000001, yields exactly 000000111010001.
- Random messages for 1000 frames, looped into the decoder with 0, 1 or 2 injected bit errors → decoded message equals the sent message every frame.
